// File: rtl/div_hilo_ctrl_pkg.sv
// div_hilo_ctrl_pkg: shared widths, constants and FSM states for the HI/LO divide sequencer
package div_hilo_ctrl_pkg;
    localparam int WIDTH = 32;
    localparam logic [WIDTH-1:0] DIV_ZERO_Q = 32'hFFFF_FFFF;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DRAIN} state_e;
endpackage

// File: rtl/div_sign_fix.sv
// div_sign_fix: conditional two's-complement negate, used for operand magnitudes and result sign
module div_sign_fix
    import div_hilo_ctrl_pkg::*;
(
    input  logic [WIDTH-1:0] a_i,
    input  logic             neg_i,
    output logic [WIDTH-1:0] y_o
);
    assign y_o = neg_i ? -a_i : a_i;
endmodule

// File: rtl/div_hilo_ctrl.sv
// div_hilo_ctrl: sequences DIV/DIVU through the external iterative divider and owns HI/LO
module div_hilo_ctrl
    import div_hilo_ctrl_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             op_valid,
    input  logic             op_signed,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             flush,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    input  logic             hilo_read,
    output logic             stall,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             done,
    output logic             div_start,
    output logic [WIDTH-1:0] div_dividend,
    output logic [WIDTH-1:0] div_divisor,
    input  logic             div_busy,
    input  logic [WIDTH-1:0] div_q,
    input  logic [WIDTH-1:0] div_r
);
    state_e           state_q;
    logic [WIDTH-1:0] hi_q, lo_q, dvd_q, dvs_q;
    logic [WIDTH-1:0] mag_a, mag_b, res_q, res_r;
    logic             done_q, start_q, neg_quo_q, neg_rem_q;
    logic             req, accept, bypass;

    assign req    = state_q == IDLE && op_valid && !flush;
    assign accept = req && op_b != '0;
    assign bypass = req && op_b == '0;
    assign stall  = state_q != IDLE && (op_valid || hi_we || lo_we || hilo_read);

    assign hi           = hi_q;
    assign lo           = lo_q;
    assign done         = done_q;
    assign div_start    = start_q;
    assign div_dividend = dvd_q;
    assign div_divisor  = dvs_q;

    div_sign_fix u_fix_a (.a_i(op_a),  .neg_i(op_signed & op_a[WIDTH-1]), .y_o(mag_a));
    div_sign_fix u_fix_b (.a_i(op_b),  .neg_i(op_signed & op_b[WIDTH-1]), .y_o(mag_b));
    div_sign_fix u_fix_q (.a_i(div_q), .neg_i(neg_quo_q),                 .y_o(res_q));
    div_sign_fix u_fix_r (.a_i(div_r), .neg_i(neg_rem_q),                 .y_o(res_r));

    // Sequencer FSM; start, done and HI/LO are all registered outputs of this block
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
            start_q   <= 1'b0;
            dvd_q     <= '0;
            dvs_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            start_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        dvd_q     <= mag_a;
                        dvs_q     <= mag_b;
                        neg_quo_q <= op_signed & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
                        neg_rem_q <= op_signed & op_a[WIDTH-1];
                        start_q   <= 1'b1;
                        state_q   <= ISSUE;
                    end
                    if (bypass) begin
                        hi_q   <= op_a;
                        lo_q   <= DIV_ZERO_Q;
                        done_q <= 1'b1;
                    end
                    if (hi_we) hi_q <= wdata;
                    if (lo_we) lo_q <= wdata;
                end
                ISSUE: state_q <= flush ? DRAIN : WAIT;
                WAIT: begin
                    if (flush) begin
                        state_q <= DRAIN;
                    end else if (!div_busy) begin
                        lo_q    <= res_q;
                        hi_q    <= res_r;
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                DRAIN: if (!div_busy) state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/div_hilo_ctrl.md
Name: div_hilo_ctrl

Overview:
Sequencer between the EX stage and the 32-bit iterative unsigned divider core (start/busy/q/r handshake, 32 busy cycles).
- Accepts DIV/DIVU requests and applies signed magnitude conversion and result sign correction.
- Issues exactly one start pulse per request and owns the architectural HI/LO registers.
- Stalls the pipeline while HI/LO are pending.

Parameters:
WIDTH, 32, operand/result width (fixed by the divider core; no other value supported)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
op_valid  in  1  divide request from EX
op_signed  in  1  1 = DIV (two's complement), 0 = DIVU
op_a  in  32  dividend
op_b  in  32  divisor
flush  in  1  pipeline flush; cancels the in-flight divide
hi_we  in  1  MTHI write
lo_we  in  1  MTLO write
wdata  in  32  MTHI/MTLO data
hilo_read  in  1  MFHI/MFLO in EX
stall  out  1  pipeline stall request (combinational)
hi  out  32  HI register (remainder)
lo  out  32  LO register (quotient)
done  out  1  one-cycle pulse when HI/LO are updated by a divide
div_start  out  1  start pulse to divider core
div_dividend  out  32  magnitude of dividend to core
div_divisor  out  32  magnitude of divisor to core
div_busy  in  1  core busy
div_q  in  32  core quotient, valid when busy falls
div_r  in  32  core remainder, valid when busy falls

Behaviour:
- Reset: state=IDLE, and all of the following are 0: hi, lo, done, div_start, div_dividend, div_divisor, neg_q, neg_r.
- States: IDLE, ISSUE, WAIT, DRAIN (2-bit encoding).
- IDLE, op_valid & !flush & op_b!=0:
  - Latch div_dividend = (op_signed & op_a[31]) ? -op_a : op_a; div_divisor likewise from op_b.
  - Latch neg_q = op_signed & (op_a[31]^op_b[31]); neg_r = op_signed & op_a[31].
  - Go to ISSUE.
- IDLE, op_valid & !flush & op_b==0 (bypass): next edge hi=op_a, lo=0xFFFFFFFF, done=1; stay IDLE; no div_start. Applies to both signed and unsigned.
- ISSUE: div_start=1 for exactly this cycle; go to WAIT. div_dividend/div_divisor stay stable until the core finishes.
- WAIT: the first WAIT cycle sees div_busy=1. When div_busy==0:
  - lo <= neg_q ? -div_q : div_q; hi <= neg_r ? -div_r : div_r; done=1.
  - Go to IDLE.
- Latency: accept edge E0, start sampled at E1, busy falls at E33, hi/lo/done updated at E34. Bypass latency is 1 cycle.
- Overflow 0x80000000 / 0xFFFFFFFF (signed) follows the normal path: lo=0x80000000, hi=0. No special casing.
- flush in ISSUE or WAIT: go to DRAIN. If in ISSUE, still complete the div_start pulse so the core and the FSM stay consistent. In DRAIN, wait for div_busy==0, discard the result, go to IDLE. hi/lo unchanged, no done.
- flush in IDLE: request ignored. flush and op_valid in the same cycle: flush wins.
- stall = (state!=IDLE) & (op_valid | hi_we | lo_we | hilo_read). A request arriving during DRAIN stalls until IDLE.
- hi_we/lo_we in IDLE: write wdata next edge. Simultaneous with a bypass result in the same cycle, the MT write wins for that register. In other states the writes are stalled and not performed.
- done is registered and high for exactly one cycle per completed divide.
- Reset mid-operation returns to IDLE immediately. The core is reset by the same signal.

Decomposition:
- Shared package: state enum (IDLE/ISSUE/WAIT/DRAIN), WIDTH constant, DIV_ZERO_Q = 32'hFFFFFFFF.
- One natural sub-module: div_sign_fix, a combinational conditional two's-complement negate, instantiated four times (two operands, two results).
- The divider core is external, connected at the top level; it is not instantiated here.

Test Plan:
The bench uses a behavioural core model: busy rises 1 edge after start, lasts 32 cycles, q/r valid when busy falls.
1. DIVU 100/7 -> lo=14, hi=2, done at E34; stall=1 with hilo_read during E1..E33; exactly one div_start.
2. DIV 0xFFFFFFF9/2 (-7/2) -> div_dividend=7, lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). Also DIV 7/0xFFFFFFFE -> lo=0xFFFFFFFD, hi=1.
3. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0. DIVU 0xFFFFFFFF/1 -> lo=0xFFFFFFFF, hi=0.
4. DIVU 5/0 and DIV 0xFFFFFFFB/0 -> 1-cycle done, lo=0xFFFFFFFF, hi=op_a, div_start never asserted. Also bypass with lo_we same cycle -> lo=wdata.
5. flush at the 10th WAIT cycle, then op_valid 9/3 -> DRAIN until busy falls, no done, hi/lo unchanged, stall held; then lo=3, hi=0.
6. reset asserted at the 20th WAIT cycle -> all outputs 0 asynchronously, state IDLE; a new 8/2 request after release gives lo=4, hi=0.
